// File: rtl/clock_time_setter_if.sv
// Time-entry bus between the setter front end and its environment.
// The slave side is the setter. It takes the raw buttons and the counter time, and it drives the edit buffer and the load strobe.
interface clock_time_setter_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] time_cur;
  logic [23:0] time_in;
  logic        set_time;
  logic        editing;
  logic [1:0]  field_sel;

  modport slave (
    input  btn_mode, btn_inc, time_cur,
    output time_in, set_time, editing, field_sel
  );

  modport master (
    output btn_mode, btn_inc, time_cur,
    input  time_in, set_time, editing, field_sel
  );
endinterface

// File: rtl/clock_time_setter.sv
// Button-driven time editor for a 24-hour BCD counter. It debounces the mode and inc buttons.
// It then steps through the hours, minutes and seconds fields and issues a one-cycle load strobe.
module clock_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  clock_time_setter_if.slave bus
);

  typedef enum logic [2:0] {RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] buf_q, buf_d;

  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q, deb_q, deb_dly_q, press_q;
  logic [7:0] cnt_q [2];
  logic       mode_evt, inc_evt;

  // Increment a two-digit BCD field with wrap at {max_t,max_o}; out-of-range values restart at 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] f, input logic [3:0] max_t,
                                         input logic [3:0] max_o);
    logic [3:0] t, o;
    t = f[7:4];
    o = f[3:0];
    if (o > 4'd9 || t > max_t || (t == max_t && o >= max_o)) return 8'h00;
    if (o == 4'd9) return {t + 4'd1, 4'd0};
    return {t, o + 4'd1};
  endfunction

  assign btn_raw  = {bus.btn_inc, bus.btn_mode};
  assign mode_evt = press_q[0];
  assign inc_evt  = press_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      press_q   <= deb_q & ~deb_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 8'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Mode takes priority, so an inc arriving on the same cycle is dropped.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      RUN: begin
        if (mode_evt) begin
          state_d = EDIT_HR;
          buf_d   = bus.time_cur;
        end
      end
      EDIT_HR: begin
        if (mode_evt)     state_d = EDIT_MIN;
        else if (inc_evt) buf_d[23:16] = bcd_inc(buf_q[23:16], 4'd2, 4'd3);
      end
      EDIT_MIN: begin
        if (mode_evt)     state_d = EDIT_SEC;
        else if (inc_evt) buf_d[15:8] = bcd_inc(buf_q[15:8], 4'd5, 4'd9);
      end
      EDIT_SEC: begin
        if (mode_evt)     state_d = COMMIT;
        else if (inc_evt) buf_d[7:0] = bcd_inc(buf_q[7:0], 4'd5, 4'd9);
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.field_sel = 2'b00;
    unique case (state_q)
      EDIT_HR:  bus.field_sel = 2'b01;
      EDIT_MIN: bus.field_sel = 2'b10;
      EDIT_SEC: bus.field_sel = 2'b11;
      default:  bus.field_sel = 2'b00;
    endcase
  end

  assign bus.time_in  = buf_q;
  assign bus.set_time = (state_q == COMMIT);
  assign bus.editing  = (state_q == EDIT_HR) || (state_q == EDIT_MIN) || (state_q == EDIT_SEC);

endmodule

// File: tb/tb_clock_time_setter.sv
// Randomized bench for clock_time_setter against a field-level model of the edit sequence.
module tb_clock_time_setter;
  localparam int D = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  clock_time_setter_if ifc();

  clock_time_setter #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 = RUN, 1..3 = editing hours/minutes/seconds
  int          m_state   = 0;
  logic [23:0] m_buf     = '0;
  int          m_commits = 0;

  function automatic logic [7:0] ref_inc(input logic [7:0] f, input int limit);
    int t = int'(f[7:4]);
    int o = int'(f[3:0]);
    int v;
    if (t > 9 || o > 9) return 8'h00;
    v = t * 10 + o;
    if (v > limit) return 8'h00;
    v = (v + 1) % (limit + 1);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_evt(input bit mode, input bit inc);
    int lo;
    if (mode) begin
      case (m_state)
        0: begin m_buf = ifc.time_cur; m_state = 1; end
        1: m_state = 2;
        2: m_state = 3;
        default: begin m_commits++; m_state = 0; end
      endcase
    end else if (inc && m_state >= 1) begin
      lo = (3 - m_state) * 8;
      m_buf[lo +: 8] = ref_inc(m_buf[lo +: 8], (m_state == 1) ? 23 : 59);
    end
  endtask

  // Strobe monitor: counts loads and checks time_in holds through the cycle after the strobe
  int          n_commit   = 0;
  logic [23:0] commit_val = '0;
  bit          chk_next   = 0;

  always @(negedge clk) begin
    if (chk_next) chk("hold_after_commit", 32'(ifc.time_in), 32'(commit_val));
    chk_next = 0;
    if (ifc.set_time) begin
      n_commit++;
      commit_val = ifc.time_in;
      chk_next   = 1;
    end
  end

  task automatic chk_model(input string tag);
    chk({tag, ".time_in"},   32'(ifc.time_in),   32'(m_buf));
    chk({tag, ".editing"},   32'(ifc.editing),   (m_state >= 1) ? 32'd1 : 32'd0);
    chk({tag, ".field_sel"}, 32'(ifc.field_sel), 32'(m_state));
    chk({tag, ".set_time"},  32'(ifc.set_time),  32'd0);
    chk({tag, ".commits"},   32'(n_commit),      32'(m_commits));
  endtask

  task automatic press(input bit mode, input bit inc, input int hold);
    @(negedge clk);
    ifc.btn_mode = mode;
    ifc.btn_inc  = inc;
    repeat (hold) @(negedge clk);
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    repeat (D + 10) @(negedge clk);
    if (hold >= D) model_evt(mode, inc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    m_state = 0;
    m_buf   = '0;
    chk("rst.time_in",   32'(ifc.time_in),   32'd0);
    chk("rst.set_time",  32'(ifc.set_time),  32'd0);
    chk("rst.editing",   32'(ifc.editing),   32'd0);
    chk("rst.field_sel", 32'(ifc.field_sel), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  found;
    int  r;
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    ifc.time_cur = 24'h123456;

    do_reset();
    n_commit  = 0;
    m_commits = 0;
    repeat (100) @(negedge clk);
    chk("idle_no_set_time", 32'(n_commit), 32'd0);
    chk_model("after_reset");

    // Press latency measured from the first sampling edge
    @(negedge clk);
    ifc.btn_mode = 1'b1;
    lat = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.editing) begin found = 1; lat = k; end
    end
    chk("mode_latency", 32'(lat), 32'(D + 3));
    ifc.btn_mode = 1'b0;
    repeat (D + 10) @(negedge clk);
    model_evt(1, 0);
    chk_model("capture");
    repeat (3) press(1, 0, D + 2);
    chk("untouched_commits", 32'(n_commit), 32'd1);
    chk("untouched_value", 32'(commit_val), 32'h123456);
    chk_model("untouched_done");

    // Hours wrap and minutes wrap
    ifc.time_cur = 24'h225930;
    press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("hr_23", 32'(ifc.time_in), 32'h235930);
    press(0, 1, D + 1);
    chk("hr_00", 32'(ifc.time_in), 32'h005930);
    press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("min_00", 32'(ifc.time_in), 32'h000030);
    press(1, 0, D + 1);
    press(1, 0, D + 1);
    chk("wrap_commit", 32'(commit_val), 32'h000030);
    chk_model("wrap_done");

    // Seconds wrap leaves minutes alone
    ifc.time_cur = 24'h000958;
    repeat (3) press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("sec_59", 32'(ifc.time_in), 32'h000959);
    press(0, 1, D + 1);
    chk("sec_00", 32'(ifc.time_in), 32'h000900);
    chk_model("sec_wrap");
    press(1, 0, D + 1);

    // Glitch, long hold, then simultaneous mode+inc
    ifc.time_cur = 24'h071500;
    press(1, 0, D + 1);
    press(0, 1, D - 1);
    chk("glitch", 32'(ifc.time_in), 32'h071500);
    press(0, 1, 50);
    chk("long_hold", 32'(ifc.time_in), 32'h081500);
    press(1, 1, D + 3);
    chk("both.field_sel", 32'(ifc.field_sel), 32'd2);
    chk("both.time_in", 32'(ifc.time_in), 32'h081500);
    chk_model("both");

    // Reset mid-edit discards the buffer
    press(0, 1, D + 1);
    press(0, 1, D + 1);
    r = n_commit;
    do_reset();
    repeat (20) @(negedge clk);
    chk("rst_no_commit", 32'(n_commit), 32'(r));
    chk_model("rst_mid_edit");
    ifc.time_cur = 24'h214512;
    press(1, 0, D + 1);
    chk("recapture", 32'(ifc.time_in), 32'h214512);
    repeat (3) press(1, 0, D + 1);

    // Out-of-range captured fields restart at 00 on first inc
    ifc.time_cur = 24'h2A6F99;
    press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("bad_hr", 32'(ifc.time_in), 32'h006F99);
    press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("bad_min", 32'(ifc.time_in), 32'h000099);
    press(1, 0, D + 1);
    press(0, 1, D + 1);
    chk("bad_sec", 32'(ifc.time_in), 32'h000000);
    press(1, 0, D + 1);
    chk_model("bad_done");

    // Random mix of operations
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin
          if ($urandom_range(0, 3) == 0)
            ifc.time_cur = 24'($urandom);
          else
            ifc.time_cur = {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                            to_bcd($urandom_range(0, 59))};
        end
        1, 2, 3:       press(1, 0, $urandom_range(D, D + 20));
        4, 5, 6, 7:    press(0, 1, $urandom_range(D, D + 20));
        8:             press(1, 1, $urandom_range(D, D + 8));
        default: begin
          if ($urandom_range(0, 1) == 0) press(1, 0, $urandom_range(1, D - 1));
          else                           press(0, 1, $urandom_range(1, D - 1));
        end
      endcase
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
